// File: rtl/rename_pkg.sv
// rename_pkg: shared constants and types for the register-rename stage.
//   ARCH_REGS/PHYS_REGS/AW/PW : register-file geometry
//   FL_DEPTH / FL_IW          : free-list depth and index width
//   arch_t / phys_t           : architectural / physical register indices
//   flptr_t                   : free-list pointer (index plus wrap bit)
// Optional feature macro used by rename_unit: RN_BUSY_TABLE_EN.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int AW        = 5;
  localparam int PW        = 6;
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int FL_IW     = $clog2(FL_DEPTH);

  typedef logic [AW-1:0]    arch_t;
  typedef logic [PW-1:0]    phys_t;
  typedef logic [FL_IW:0]   flptr_t;
  typedef logic [FL_IW-1:0] flidx_t;

  // Identity mapping used for both RATs at reset.
  function automatic phys_t reset_map(input int i);
    return phys_t'(i);
  endfunction

  // r0 is hardwired zero regardless of the table contents.
  function automatic phys_t map_src(input arch_t a, input phys_t m);
    return (a == '0) ? '0 : m;
  endfunction
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular free list of physical registers.
//   clk, rst      : clock, async active-high reset
//   flush         : speculative head <= committed head (after this cycle's commits)
//   pop_cnt_i     : registers allocated this cycle (0..2), already gated by fire
//   pushN_en_i/pushN_i : freed registers from commit slot N (slot 1 lands first)
//   pop0_o/pop1_o : entries at head and head+1
//   count_o       : free entries visible to the speculative head
// Every commit retires one allocation, so the committed head advances once per push.
module rename_free_list
  import rename_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [1:0] pop_cnt_i,
  input  logic       push0_en_i,
  input  phys_t      push0_i,
  input  logic       push1_en_i,
  input  phys_t      push1_i,
  output phys_t      pop0_o,
  output phys_t      pop1_o,
  output flptr_t     count_o
);
  phys_t      mem_q [FL_DEPTH];
  flptr_t     head_q, chead_q, tail_q;
  flptr_t     head_d, chead_d;
  logic [1:0] push_cnt;
  flidx_t     hidx1, tidx1;

  assign push_cnt = {1'b0, push0_en_i} + {1'b0, push1_en_i};
  assign chead_d  = chead_q + flptr_t'(push_cnt);
  assign head_d   = flush ? chead_d : head_q + flptr_t'(pop_cnt_i);
  assign hidx1    = head_q[FL_IW-1:0] + flidx_t'(1);
  // A lone slot-2 push lands at the tail itself.
  assign tidx1    = tail_q[FL_IW-1:0] + flidx_t'(push0_en_i);

  assign pop0_o  = mem_q[head_q[FL_IW-1:0]];
  assign pop1_o  = mem_q[hidx1];
  assign count_o = tail_q - head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) mem_q[k] <= phys_t'(ARCH_REGS + k);
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= flptr_t'(FL_DEPTH);
    end else begin
      if (push0_en_i) mem_q[tail_q[FL_IW-1:0]] <= push0_i;
      if (push1_en_i) mem_q[tidx1] <= push1_i;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_q + flptr_t'(push_cnt);
    end
  end
endmodule

// File: rtl/rename_unit.sv
// rename_unit: 2-wide register rename with speculative/committed RATs.
//   clk, rst, flush, Stall : clock, async reset, flush restore, downstream stall
//   RN_Stall               : free list cannot cover this cycle's allocations
//   ID_InstN_*             : instruction pair to rename (N = 1,2)
//   RE_InstN_*             : renamed sources, new and previous destination mappings
//   CM_InstN_*             : committing instructions (update committed RAT, free old regs)
// Optional (macro RN_BUSY_TABLE_EN): WB_Valid/WB_Phydst writeback inputs and
// RE_InstN_SrcMRdy ready flags backed by a per-physical-register ready table.
// Outputs are combinational; the downstream pipeline register latches them.
module rename_unit
  import rename_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       Stall,
  output logic       RN_Stall,
  input  logic       ID_Inst1_Valid,
  input  logic       ID_Inst1_WrEn,
  input  logic [4:0] ID_Inst1_Src1,
  input  logic [4:0] ID_Inst1_Src2,
  input  logic [4:0] ID_Inst1_Rdst,
  input  logic       ID_Inst2_Valid,
  input  logic       ID_Inst2_WrEn,
  input  logic [4:0] ID_Inst2_Src1,
  input  logic [4:0] ID_Inst2_Src2,
  input  logic [4:0] ID_Inst2_Rdst,
  output logic [5:0] RE_Inst1_RSrc1,
  output logic [5:0] RE_Inst1_RSrc2,
  output logic [5:0] RE_Inst1_Phydst,
  output logic [5:0] RE_Inst1_OldPhydst,
  output logic [5:0] RE_Inst2_RSrc1,
  output logic [5:0] RE_Inst2_RSrc2,
  output logic [5:0] RE_Inst2_Phydst,
  output logic [5:0] RE_Inst2_OldPhydst,
`ifdef RN_BUSY_TABLE_EN
  input  logic [1:0]         WB_Valid,
  input  logic [1:0][PW-1:0] WB_Phydst,
  output logic               RE_Inst1_Src1Rdy,
  output logic               RE_Inst1_Src2Rdy,
  output logic               RE_Inst2_Src1Rdy,
  output logic               RE_Inst2_Src2Rdy,
`endif
  input  logic       CM_Inst1_Valid,
  input  logic       CM_Inst1_WrEn,
  input  logic [4:0] CM_Inst1_Rdst,
  input  logic [5:0] CM_Inst1_Phydst,
  input  logic [5:0] CM_Inst1_OldPhydst,
  input  logic       CM_Inst2_Valid,
  input  logic       CM_Inst2_WrEn,
  input  logic [4:0] CM_Inst2_Rdst,
  input  logic [5:0] CM_Inst2_Phydst,
  input  logic [5:0] CM_Inst2_OldPhydst
);
  phys_t      rat_q [ARCH_REGS];
  phys_t      rat_d [ARCH_REGS];
  phys_t      crat_q[ARCH_REGS];
  phys_t      crat_d[ARCH_REGS];
  logic       alloc1, alloc2, cm1, cm2, fire, fwd21, fwd22, same_dst;
  logic [1:0] need;
  flptr_t     fl_count;
  phys_t      pop0, pop1, phy1, phy2;

  assign alloc1 = ID_Inst1_Valid & ID_Inst1_WrEn & (ID_Inst1_Rdst != '0);
  assign alloc2 = ID_Inst2_Valid & ID_Inst2_WrEn & (ID_Inst2_Rdst != '0);
  assign cm1    = CM_Inst1_Valid & CM_Inst1_WrEn & (CM_Inst1_Rdst != '0);
  assign cm2    = CM_Inst2_Valid & CM_Inst2_WrEn & (CM_Inst2_Rdst != '0);
  assign need   = {1'b0, alloc1} + {1'b0, alloc2};

  // Judged on the pre-edge count: registers freed by this cycle's commits
  // are not usable until next cycle.
  assign RN_Stall = fl_count < flptr_t'(need);
  assign fire     = ~Stall & ~RN_Stall & ~flush;

  assign phy1 = alloc1 ? pop0 : '0;
  assign phy2 = alloc2 ? (alloc1 ? pop1 : pop0) : '0;

  // Intra-pair dependencies: slot 2 sees slot 1's new destination.
  assign fwd21    = alloc1 & (ID_Inst2_Src1 == ID_Inst1_Rdst);
  assign fwd22    = alloc1 & (ID_Inst2_Src2 == ID_Inst1_Rdst);
  assign same_dst = alloc1 & (ID_Inst2_Rdst == ID_Inst1_Rdst);

  assign RE_Inst1_RSrc1     = map_src(ID_Inst1_Src1, rat_q[ID_Inst1_Src1]);
  assign RE_Inst1_RSrc2     = map_src(ID_Inst1_Src2, rat_q[ID_Inst1_Src2]);
  assign RE_Inst2_RSrc1     = fwd21 ? phy1 : map_src(ID_Inst2_Src1, rat_q[ID_Inst2_Src1]);
  assign RE_Inst2_RSrc2     = fwd22 ? phy1 : map_src(ID_Inst2_Src2, rat_q[ID_Inst2_Src2]);
  assign RE_Inst1_Phydst    = phy1;
  assign RE_Inst2_Phydst    = phy2;
  assign RE_Inst1_OldPhydst = alloc1 ? rat_q[ID_Inst1_Rdst] : '0;
  assign RE_Inst2_OldPhydst = alloc2 ? (same_dst ? phy1 : rat_q[ID_Inst2_Rdst]) : '0;

  rename_free_list u_fl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pop_cnt_i  (fire ? need : 2'd0),
    .push0_en_i (cm1),
    .push0_i    (CM_Inst1_OldPhydst),
    .push1_en_i (cm2),
    .push1_i    (CM_Inst2_OldPhydst),
    .pop0_o     (pop0),
    .pop1_o     (pop1),
    .count_o    (fl_count)
  );

  // Slot 2 is written last so it wins on equal destinations.
  always_comb begin
    crat_d = crat_q;
    if (cm1) crat_d[CM_Inst1_Rdst] = CM_Inst1_Phydst;
    if (cm2) crat_d[CM_Inst2_Rdst] = CM_Inst2_Phydst;
    rat_d = rat_q;
    if (flush) rat_d = crat_d;
    else if (fire) begin
      if (alloc1) rat_d[ID_Inst1_Rdst] = phy1;
      if (alloc2) rat_d[ID_Inst2_Rdst] = phy2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= reset_map(i);
        crat_q[i] <= reset_map(i);
      end
    end else begin
      rat_q  <= rat_d;
      crat_q <= crat_d;
    end
  end

`ifdef RN_BUSY_TABLE_EN
  logic [PHYS_REGS-1:0] rdy_q, rdy_d, wb_hit, rdy_view;

  always_comb begin
    wb_hit = '0;
    for (int w = 0; w < 2; w++) if (WB_Valid[w]) wb_hit[WB_Phydst[w]] = 1'b1;
    rdy_d = rdy_q | wb_hit;
    if (fire) begin
      if (alloc1) rdy_d[phy1] = 1'b0;
      if (alloc2) rdy_d[phy2] = 1'b0;
    end
    if (flush) rdy_d = '1;
  end

  // Same-cycle writebacks bypass the table.
  assign rdy_view         = rdy_q | wb_hit;
  assign RE_Inst1_Src1Rdy = rdy_view[RE_Inst1_RSrc1];
  assign RE_Inst1_Src2Rdy = rdy_view[RE_Inst1_RSrc2];
  assign RE_Inst2_Src1Rdy = ~fwd21 & rdy_view[RE_Inst2_RSrc1];
  assign RE_Inst2_Src2Rdy = ~fwd22 & rdy_view[RE_Inst2_RSrc2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= '1;
    else     rdy_q <= rdy_d;
  end
`endif
endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;
  logic clk = 1'b0;
  logic rst, flush, Stall, RN_Stall;
  logic ID_Inst1_Valid, ID_Inst1_WrEn, ID_Inst2_Valid, ID_Inst2_WrEn;
  logic [4:0] ID_Inst1_Src1, ID_Inst1_Src2, ID_Inst1_Rdst;
  logic [4:0] ID_Inst2_Src1, ID_Inst2_Src2, ID_Inst2_Rdst;
  logic [5:0] RE_Inst1_RSrc1, RE_Inst1_RSrc2, RE_Inst1_Phydst, RE_Inst1_OldPhydst;
  logic [5:0] RE_Inst2_RSrc1, RE_Inst2_RSrc2, RE_Inst2_Phydst, RE_Inst2_OldPhydst;
  logic CM_Inst1_Valid, CM_Inst1_WrEn, CM_Inst2_Valid, CM_Inst2_WrEn;
  logic [4:0] CM_Inst1_Rdst, CM_Inst2_Rdst;
  logic [5:0] CM_Inst1_Phydst, CM_Inst1_OldPhydst, CM_Inst2_Phydst, CM_Inst2_OldPhydst;
`ifdef RN_BUSY_TABLE_EN
  logic [1:0]      WB_Valid = '0;
  logic [1:0][5:0] WB_Phydst = '0;
  logic RE_Inst1_Src1Rdy, RE_Inst1_Src2Rdy, RE_Inst2_Src1Rdy, RE_Inst2_Src2Rdy;
`endif

  always #5 clk = ~clk;

  rename_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .Stall(Stall), .RN_Stall(RN_Stall),
    .ID_Inst1_Valid(ID_Inst1_Valid), .ID_Inst1_WrEn(ID_Inst1_WrEn),
    .ID_Inst1_Src1(ID_Inst1_Src1), .ID_Inst1_Src2(ID_Inst1_Src2), .ID_Inst1_Rdst(ID_Inst1_Rdst),
    .ID_Inst2_Valid(ID_Inst2_Valid), .ID_Inst2_WrEn(ID_Inst2_WrEn),
    .ID_Inst2_Src1(ID_Inst2_Src1), .ID_Inst2_Src2(ID_Inst2_Src2), .ID_Inst2_Rdst(ID_Inst2_Rdst),
    .RE_Inst1_RSrc1(RE_Inst1_RSrc1), .RE_Inst1_RSrc2(RE_Inst1_RSrc2),
    .RE_Inst1_Phydst(RE_Inst1_Phydst), .RE_Inst1_OldPhydst(RE_Inst1_OldPhydst),
    .RE_Inst2_RSrc1(RE_Inst2_RSrc1), .RE_Inst2_RSrc2(RE_Inst2_RSrc2),
    .RE_Inst2_Phydst(RE_Inst2_Phydst), .RE_Inst2_OldPhydst(RE_Inst2_OldPhydst),
`ifdef RN_BUSY_TABLE_EN
    .WB_Valid(WB_Valid), .WB_Phydst(WB_Phydst),
    .RE_Inst1_Src1Rdy(RE_Inst1_Src1Rdy), .RE_Inst1_Src2Rdy(RE_Inst1_Src2Rdy),
    .RE_Inst2_Src1Rdy(RE_Inst2_Src1Rdy), .RE_Inst2_Src2Rdy(RE_Inst2_Src2Rdy),
`endif
    .CM_Inst1_Valid(CM_Inst1_Valid), .CM_Inst1_WrEn(CM_Inst1_WrEn), .CM_Inst1_Rdst(CM_Inst1_Rdst),
    .CM_Inst1_Phydst(CM_Inst1_Phydst), .CM_Inst1_OldPhydst(CM_Inst1_OldPhydst),
    .CM_Inst2_Valid(CM_Inst2_Valid), .CM_Inst2_WrEn(CM_Inst2_WrEn), .CM_Inst2_Rdst(CM_Inst2_Rdst),
    .CM_Inst2_Phydst(CM_Inst2_Phydst), .CM_Inst2_OldPhydst(CM_Inst2_OldPhydst)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: architectural maps as plain arrays; the committed free
  // list as a queue (front = oldest free reg), with the speculative view being
  // that queue minus its first 'spec' entries. Renamed-but-uncommitted
  // instructions sit in an in-order ROB that feeds the commit ports.
  typedef struct { bit wr; logic [4:0] rd; logic [5:0] phy, old; } rob_t;
  int   mrat[32], crat[32];
  int   cfree[$];
  int   spec;
  rob_t rob[$];
  int   ncm;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mrat[i] = i; crat[i] = i; end
    cfree.delete();
    for (int k = 0; k < 32; k++) cfree.push_back(32 + k);
    spec = 0;
    rob.delete();
  endtask

  function automatic int lk(input logic [4:0] r);
    return (r == 0) ? 0 : mrat[r];
  endfunction

  task automatic idle();
    flush = 0; Stall = 0;
    {ID_Inst1_Valid, ID_Inst1_WrEn, ID_Inst1_Src1, ID_Inst1_Src2, ID_Inst1_Rdst} = '0;
    {ID_Inst2_Valid, ID_Inst2_WrEn, ID_Inst2_Src1, ID_Inst2_Src2, ID_Inst2_Rdst} = '0;
    {CM_Inst1_Valid, CM_Inst1_WrEn, CM_Inst1_Rdst, CM_Inst1_Phydst, CM_Inst1_OldPhydst} = '0;
    {CM_Inst2_Valid, CM_Inst2_WrEn, CM_Inst2_Rdst, CM_Inst2_Phydst, CM_Inst2_OldPhydst} = '0;
    ncm = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic slot(input int n, input bit v, input bit w, input int rd, input int s1, input int s2);
    if (n == 1) begin
      ID_Inst1_Valid = v; ID_Inst1_WrEn = w; ID_Inst1_Rdst = 5'(rd);
      ID_Inst1_Src1 = 5'(s1); ID_Inst1_Src2 = 5'(s2);
    end else begin
      ID_Inst2_Valid = v; ID_Inst2_WrEn = w; ID_Inst2_Rdst = 5'(rd);
      ID_Inst2_Src1 = 5'(s1); ID_Inst2_Src2 = 5'(s2);
    end
  endtask

  // Drive up to n oldest ROB entries onto the commit ports; a lone commit may use slot 2.
  task automatic set_commit(input int n, input bit use2);
    {CM_Inst1_Valid, CM_Inst1_WrEn, CM_Inst1_Rdst, CM_Inst1_Phydst, CM_Inst1_OldPhydst} = '0;
    {CM_Inst2_Valid, CM_Inst2_WrEn, CM_Inst2_Rdst, CM_Inst2_Phydst, CM_Inst2_OldPhydst} = '0;
    ncm = (n > rob.size()) ? rob.size() : n;
    if (ncm == 1 && use2) begin
      CM_Inst2_Valid = 1; CM_Inst2_WrEn = rob[0].wr; CM_Inst2_Rdst = rob[0].rd;
      CM_Inst2_Phydst = rob[0].phy; CM_Inst2_OldPhydst = rob[0].old;
    end else if (ncm >= 1) begin
      CM_Inst1_Valid = 1; CM_Inst1_WrEn = rob[0].wr; CM_Inst1_Rdst = rob[0].rd;
      CM_Inst1_Phydst = rob[0].phy; CM_Inst1_OldPhydst = rob[0].old;
    end
    if (ncm == 2) begin
      CM_Inst2_Valid = 1; CM_Inst2_WrEn = rob[1].wr; CM_Inst2_Rdst = rob[1].rd;
      CM_Inst2_Phydst = rob[1].phy; CM_Inst2_OldPhydst = rob[1].old;
    end
  endtask

  task automatic commit_one(input rob_t e);
    if (e.wr && e.rd != 0) begin
      crat[e.rd] = e.phy;
      void'(cfree.pop_front());
      spec--;
      cfree.push_back(e.old);
    end
  endtask

  // At negedge: compare DUT against the model, then advance the model to the next edge.
  task automatic settle();
    int a1, a2, need, avail, e1, e2, o1, o2;
    bit ok1, ok2, fire;
    rob_t r;
    @(negedge clk);
    a1 = (ID_Inst1_Valid && ID_Inst1_WrEn && ID_Inst1_Rdst != 0) ? 1 : 0;
    a2 = (ID_Inst2_Valid && ID_Inst2_WrEn && ID_Inst2_Rdst != 0) ? 1 : 0;
    need  = a1 + a2;
    avail = cfree.size() - spec;
    ok1 = avail >= 1;
    ok2 = avail >= a1 + 1;
    e1 = (a1 == 1 && ok1) ? cfree[spec] : 0;
    e2 = (a2 == 1 && ok2) ? cfree[spec + a1] : 0;
    o1 = mrat[ID_Inst1_Rdst];
    o2 = (a1 == 1 && ID_Inst2_Rdst == ID_Inst1_Rdst) ? e1 : mrat[ID_Inst2_Rdst];
    chk("rn_stall", RN_Stall, avail < need);
    if (ID_Inst1_Valid) begin
      chk("i1_src1", RE_Inst1_RSrc1, lk(ID_Inst1_Src1));
      chk("i1_src2", RE_Inst1_RSrc2, lk(ID_Inst1_Src2));
    end
    if (ID_Inst2_Valid) begin
      if (a1 == 1 && ID_Inst2_Src1 == ID_Inst1_Rdst) begin if (ok1) chk("i2_src1_fwd", RE_Inst2_RSrc1, e1); end
      else chk("i2_src1", RE_Inst2_RSrc1, lk(ID_Inst2_Src1));
      if (a1 == 1 && ID_Inst2_Src2 == ID_Inst1_Rdst) begin if (ok1) chk("i2_src2_fwd", RE_Inst2_RSrc2, e1); end
      else chk("i2_src2", RE_Inst2_RSrc2, lk(ID_Inst2_Src2));
    end
    if (a1 == 0) chk("i1_phy_none", RE_Inst1_Phydst, 0);
    else if (ok1) begin
      chk("i1_phy", RE_Inst1_Phydst, e1);
      chk("i1_old", RE_Inst1_OldPhydst, o1);
    end
    if (a2 == 0) chk("i2_phy_none", RE_Inst2_Phydst, 0);
    else if (ok2) begin
      chk("i2_phy", RE_Inst2_Phydst, e2);
      if (ok1) chk("i2_old", RE_Inst2_OldPhydst, o2);
    end
    // model update
    fire = !Stall && !(avail < need) && !flush;
    for (int i = 0; i < ncm; i++) begin
      r = rob.pop_front();
      commit_one(r);
    end
    if (fire) begin
      if (ID_Inst1_Valid) rob.push_back('{ID_Inst1_WrEn, ID_Inst1_Rdst, 6'(e1), a1 == 1 ? 6'(o1) : 6'd0});
      if (ID_Inst2_Valid) rob.push_back('{ID_Inst2_WrEn, ID_Inst2_Rdst, 6'(e2), a2 == 1 ? 6'(o2) : 6'd0});
      if (a1 == 1) mrat[ID_Inst1_Rdst] = e1;
      if (a2 == 1) mrat[ID_Inst2_Rdst] = e2;
      spec += need;
    end
    if (flush) begin
      mrat = crat;
      spec = 0;
      rob.delete();
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 0;
    idle();
    #2 rst = 1;
    #10;
    do_reset();

    // 1: dependent pair after reset
    slot(1, 1, 1, 1, 2, 3);
    slot(2, 1, 1, 4, 1, 5);
    settle();
    chk("t1_i1_src1", RE_Inst1_RSrc1, 2);
    chk("t1_i1_src2", RE_Inst1_RSrc2, 3);
    chk("t1_i1_phy", RE_Inst1_Phydst, 32);
    chk("t1_i1_old", RE_Inst1_OldPhydst, 1);
    chk("t1_i2_src1", RE_Inst2_RSrc1, 32);
    chk("t1_i2_src2", RE_Inst2_RSrc2, 5);
    chk("t1_i2_phy", RE_Inst2_Phydst, 33);
    chk("t1_i2_old", RE_Inst2_OldPhydst, 4);
    adv();

    // 2: both slots write r7
    do_reset();
    slot(1, 1, 1, 7, 0, 0);
    slot(2, 1, 1, 7, 0, 0);
    settle();
    chk("t2_i1_phy", RE_Inst1_Phydst, 32);
    chk("t2_i2_phy", RE_Inst2_Phydst, 33);
    chk("t2_i2_old", RE_Inst2_OldPhydst, 32);
    adv();
    idle();
    slot(1, 1, 0, 0, 7, 0);
    settle();
    chk("t2_r7", RE_Inst1_RSrc1, 33);
    adv();

    // 3: drain the free list, then recycle a committed register
    do_reset();
    for (int c = 0; c < 16; c++) begin
      slot(1, 1, 1, c == 0 ? 7 : 1 + (c % 31), 0, 0);
      slot(2, 1, 1, c == 0 ? 8 : 2 + (c % 29), 0, 0);
      settle(); adv();
    end
    settle();
    chk("t3_stall_empty", RN_Stall, 1);
    adv();
    idle();
    set_commit(1, 0);
    settle(); adv();
    idle();
    slot(1, 1, 1, 9, 0, 0);
    slot(2, 1, 1, 10, 0, 0);
    settle();
    chk("t3_stall_dual", RN_Stall, 1);
    adv();
    idle();
    slot(1, 1, 1, 9, 0, 0);
    settle();
    chk("t3_recycled", RE_Inst1_Phydst, 7);
    chk("t3_single_ok", RN_Stall, 0);
    adv();

    // 4: non-allocating slots with an empty free list
    idle();
    slot(1, 1, 1, 0, 3, 4);
    slot(2, 1, 0, 5, 6, 7);
    settle();
    chk("t4_stall", RN_Stall, 0);
    chk("t4_i1_phy", RE_Inst1_Phydst, 0);
    chk("t4_i2_phy", RE_Inst2_Phydst, 0);
    adv();

    // 5: flush with no commits restores reset mapping
    do_reset();
    slot(1, 1, 1, 1, 0, 0);
    slot(2, 1, 1, 2, 0, 0);
    settle(); adv();
    idle();
    slot(1, 1, 1, 3, 0, 0);
    settle(); adv();
    idle();
    flush = 1;
    settle(); adv();
    idle();
    slot(1, 1, 1, 4, 1, 0);
    settle();
    chk("t5_r1", RE_Inst1_RSrc1, 1);
    chk("t5_phy", RE_Inst1_Phydst, 32);
    adv();

    // 6: stall held with commits active
    do_reset();
    slot(1, 1, 1, 1, 0, 0);
    slot(2, 1, 1, 2, 0, 0);
    settle(); adv();
    idle();
    slot(1, 1, 1, 3, 0, 0);
    settle(); adv();
    for (int c = 0; c < 3; c++) begin
      idle();
      Stall = 1;
      slot(1, 1, 1, 5, 1, 2);
      slot(2, 1, 1, 6, 3, 5);
      set_commit(1, c == 1);
      settle();
      chk("t6_i1_phy", RE_Inst1_Phydst, 35);
      chk("t6_i1_src1", RE_Inst1_RSrc1, 32);
      chk("t6_i2_src1", RE_Inst2_RSrc1, 34);
      adv();
    end
    idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      idle();
      slot(1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rnd_reg(), rnd_reg(), rnd_reg());
      slot(2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rnd_reg(), rnd_reg(), rnd_reg());
      Stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 29) == 0);
      set_commit($urandom_range(0, 2), $urandom_range(0, 1) == 1);
      settle(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage of the 2-wide in-order front end; sits directly upstream of the rename/dispatch pipeline register.
- Maps architectural sources/destinations of an instruction pair to physical registers using a speculative RAT and a circular free list.
- Keeps a committed RAT and a committed free-list head for flush recovery; reclaims old physical registers on commit.

Parameters:
ARCH_REGS, 32, architectural registers (r0 hardwired zero)
PHYS_REGS, 64, physical registers
AW, 5, architectural index width
PW, 6, physical index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush; restore committed state
Stall  in  1  downstream stall; freezes rename
RN_Stall  out  1  free list cannot cover this cycle's allocations
ID_InstN_Valid  in  1  slot N (N=1,2) valid
ID_InstN_WrEn  in  1  slot N writes Rdst
ID_InstN_Src1, ID_InstN_Src2, ID_InstN_Rdst  in  5 each  architectural indices
RE_InstN_RSrc1, RE_InstN_RSrc2  out  6 each  renamed sources
RE_InstN_Phydst  out  6  newly allocated destination (0 if none)
RE_InstN_OldPhydst  out  6  previous mapping of Rdst (0 if none)
CM_InstN_Valid, CM_InstN_WrEn  in  1 each  commit slot N
CM_InstN_Rdst  in  5  committed architectural destination
CM_InstN_Phydst, CM_InstN_OldPhydst  in  6 each  committed new and old mappings

Behaviour:
- Reset (async): RAT[i]=cRAT[i]=i; free-list entry k = 32+k (k=0..31); head=cHead=0, tail=32; pointers 6-bit (5-bit index + wrap bit); count=tail-head=32.
- Outputs combinational from current state; the downstream pipeline register provides the stage latch.
- allocN = ID_InstN_Valid & ID_InstN_WrEn & (Rdst!=0); need = alloc1+alloc2.
- RN_Stall = (count < need), computed from the pre-edge count; same-cycle frees do not count.
- fire = !Stall & !RN_Stall & !flush. On fire: head += need; RAT[Rdst1]=Phydst1; RAT[Rdst2]=Phydst2 (slot 2 wins if equal).
- Phydst1 = free[head] if alloc1. Phydst2 = free[head+alloc1] if alloc2. Non-allocating slots output 0.
- Sources: RAT lookup; r0 always maps to 0. Slot-2 source equal to Rdst1 with alloc1 takes Phydst1.
- OldPhydst1 = RAT[Rdst1]. OldPhydst2 = Phydst1 when Rdst2==Rdst1 and alloc1, else RAT[Rdst2].
- Commit, independent of Stall and flush: for each slot with Valid & WrEn & Rdst!=0:
  - cRAT[Rdst] = Phydst (slot 2 wins if equal).
  - Push OldPhydst at tail (slot 1 first).
  - cHead += 1.
- Flush: RAT <= cRAT and head <= cHead, both including same-cycle commit updates; no allocation that cycle.
- Invalid slots: no effect. count never exceeds 32 by construction.
- rst mid-operation: immediate return to reset state.

Optional Feature:
RN_BUSY_TABLE_EN:
- Defined:
  - Adds a 64-bit ready table and inputs WB_Valid[1:0] / WB_Phydst (2x6).
  - Adds outputs RE_InstN_Src1Rdy / Src2Rdy.
  - Allocation clears the bit; writeback sets it; reset and flush set all bits.
  - Same-cycle writeback bypasses to the ready outputs.
  - Slot-2 source forwarded from slot 1 reads not-ready.
- Undefined: none of these ports or state exist.

Decomposition:
- Package rename_pkg: AW/PW/ARCH_REGS/PHYS_REGS constants, free-list depth, reset-mapping function, phys_t/arch_t typedefs.
- Sub-module rename_free_list: circular buffer with speculative head, committed head and tail; 2 pops, 2 pushes, flush restore.

Test Plan:
1. After reset, Inst1 r1<-r2,r3 and Inst2 r4<-r1,r5 -> Inst1 RSrc 2,3, Phydst 32, Old 1; Inst2 RSrc 32,5, Phydst 33, Old 4.
2. Both slots write r7 -> Phydst 32/33, OldPhydst2=32; next cycle Src r7 reads 33.
3. 16 dual-alloc cycles, then dual request -> RN_Stall=1, head unchanged. Commit freeing 7 -> next cycle single alloc gets Phydst 7; dual request still stalls.
4. Rdst=0 or WrEn=0 -> Phydst 0, RN_Stall=0 with count 0, head unchanged.
5. Rename 3 destinations, flush with no commits -> r1 maps to 1, count 32, next alloc returns 32.
6. Stall held 3 cycles with commits active -> rename outputs stable, no RAT/head change, tail advances per commit.
